vuprs_sample_scheduler: RTL

Parametrised successor to the fixed 20 kHz toggle-divider that drives the AD7606 controller's `usr_trigger`. Generates registered rising-edge trigger pulses at a runtime-programmable period. Supports stop, continuous, burst and single-shot modes. Skips (and counts) triggers that would land while the controller is still sampling. Sits between the system control logic and the ad7606 controller in vuprs_adc_top.

---
 rtl/vuprs_adc_pkg.sv | 21 ++
 rtl/vuprs_sat_counter.sv | 26 ++
 rtl/vuprs_sample_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vuprs_adc_pkg.sv
// Shared encodings and defaults for the vuprs ADC sample scheduler.
// Contents: mode and state encodings, default clock and sample-rate constants.
package vuprs_adc_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEF     = 50_000_000;
    localparam int unsigned DEFAULT_RATE_HZ_DEF = 20_000;

    typedef enum logic [1:0] {
        MODE_STOP       = 2'd0,
        MODE_CONTINUOUS = 2'd1,
        MODE_BURST      = 2'd2,
        MODE_SINGLE     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vuprs_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-low), clr (clear; clr with inc loads 1),
//        inc (count one event), count (registered value, sticks at all-ones).
module vuprs_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // A clear coincident with an event counts that event, so a run's first
    // trigger lands on a fresh counter without losing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= WIDTH'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vuprs_sample_scheduler.sv
// Programmable-period trigger generator for the AD7606 controller usr_trigger.
// Modes: STOP, CONTINUOUS, BURST, SINGLE. Slots that land while the controller
// is still sampling are skipped and counted as overruns.
// Ports:
//   clk, rst (sync, active-low)
//   cfg_divisor/cfg_mode/cfg_burst_len, cfg_load : configuration + capture strobe
//   start, stop                                  : control strobes
//   adc_sampling                                 : controller busy
//   trigger, running, burst_done                 : registered status/pulses
//   trig_count, overrun_count                    : saturating counters
//   ts_last                                      : timestamp of last trigger rise
// Optional: define SAMPLE_SCHED_TIMESTAMP_EN to build the 32-bit cycle counter
// behind ts_last; otherwise ts_last is tied to 0.
module vuprs_sample_scheduler
    import vuprs_adc_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_HZ_DEF,
    parameter int unsigned DEFAULT_RATE_HZ = DEFAULT_RATE_HZ_DEF,
    parameter int unsigned DIV_WIDTH       = 25,
    parameter int unsigned BURST_WIDTH     = 16,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIV_WIDTH-1:0]   cfg_divisor,
    input  logic [1:0]             cfg_mode,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic                   cfg_load,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   adc_sampling,
    output logic                   trigger,
    output logic                   running,
    output logic                   burst_done,
    output logic [BURST_WIDTH-1:0] trig_count,
    output logic [BURST_WIDTH-1:0] overrun_count,
    output logic [31:0]            ts_last
);

    localparam int unsigned MIN_DIV     = 2 * PULSE_CYCLES - 1;
    localparam int unsigned RST_DIV_RAW = CLK_FREQ_HZ / DEFAULT_RATE_HZ - 1;
    localparam int unsigned RST_DIV     = (RST_DIV_RAW < MIN_DIV) ? MIN_DIV : RST_DIV_RAW;
    localparam int unsigned TMO         = 2 * PULSE_CYCLES;
    localparam int unsigned TMR_W       = $clog2(TMO);
    localparam int unsigned BW1         = BURST_WIDTH + 1;

    // Period may never be shorter than two pulse widths.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : d;
    endfunction

    state_t                 state;
    mode_t                  sh_mode;
    mode_t                  run_mode;
    logic [DIV_WIDTH-1:0]   sh_div;
    logic [DIV_WIDTH-1:0]   act_div;
    logic [DIV_WIDTH-1:0]   phase;
    logic [BURST_WIDTH-1:0] sh_burst;
    logic [BURST_WIDTH-1:0] run_burst;
    logic [TMR_W-1:0]       drain_tmr;
    logic                   drain_seen;

    // Config as seen this cycle: a coincident cfg_load overrides the shadow.
    logic [DIV_WIDTH-1:0]   sel_div;
    mode_t                  sel_mode;
    logic [BURST_WIDTH-1:0] sel_burst;
    assign sel_div   = cfg_load ? clamp_div(cfg_divisor) : sh_div;
    assign sel_mode  = cfg_load ? mode_t'(cfg_mode)      : sh_mode;
    assign sel_burst = cfg_load ? cfg_burst_len          : sh_burst;

    // Start/slot decode. stop beats everything else in the same cycle.
    logic start_ok, burst_zero, go, wrap, slot, fire, skip, last, burst_reached;
    logic pulse_on, drain_exit;
    mode_t                  cur_mode;
    logic [BURST_WIDTH-1:0] cur_burst;
    logic [BURST_WIDTH-1:0] cnt_base;
    logic [DIV_WIDTH-1:0]   phase_inc;

    assign start_ok   = start && !stop && (state == ST_IDLE) && (sel_mode != MODE_STOP);
    assign burst_zero = start_ok && (sel_mode == MODE_BURST) && (sel_burst == '0);
    assign go         = start_ok && !burst_zero;
    assign wrap       = (state == ST_RUN) && !stop && (phase == act_div);
    assign slot       = go || wrap;
    assign fire       = slot && !adc_sampling;
    assign skip       = slot && adc_sampling;

    // Mode and burst length are frozen for the run at start.
    assign cur_mode      = go ? sel_mode  : run_mode;
    assign cur_burst     = go ? sel_burst : run_burst;
    assign cnt_base      = go ? '0        : trig_count;
    assign burst_reached = (BW1'(cnt_base) + BW1'(1)) >= BW1'(cur_burst);
    assign last          = fire && ((cur_mode == MODE_SINGLE) ||
                                    ((cur_mode == MODE_BURST) && burst_reached));

    assign phase_inc = phase + DIV_WIDTH'(1);
    assign pulse_on  = phase_inc < DIV_WIDTH'(PULSE_CYCLES);

    // Drain ends once the pulse is over and the controller has finished a
    // conversion, or never started one within the timeout window.
    assign drain_exit = (state == ST_DRAIN) && !stop && !trigger && !adc_sampling &&
                        (drain_seen || (drain_tmr == TMR_W'(TMO - 1)));

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sh_div     <= DIV_WIDTH'(RST_DIV);
            act_div    <= DIV_WIDTH'(RST_DIV);
            sh_mode    <= MODE_STOP;
            run_mode   <= MODE_STOP;
            sh_burst   <= BURST_WIDTH'(1);
            run_burst  <= BURST_WIDTH'(1);
            phase      <= '0;
            drain_tmr  <= '0;
            drain_seen <= 1'b0;
            trigger    <= 1'b0;
            running    <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (cfg_load) begin
                sh_div   <= clamp_div(cfg_divisor);
                sh_mode  <= mode_t'(cfg_mode);
                sh_burst <= cfg_burst_len;
            end
            if (stop) begin
                state   <= ST_IDLE;
                running <= 1'b0;
                trigger <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        act_div <= sel_div;
                        if (burst_zero) begin
                            burst_done <= 1'b1;
                        end
                        if (go) begin
                            state      <= last ? ST_DRAIN : ST_RUN;
                            running    <= 1'b1;
                            phase      <= '0;
                            trigger    <= fire;
                            run_mode   <= sel_mode;
                            run_burst  <= sel_burst;
                            drain_tmr  <= '0;
                            drain_seen <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            // New divisor only at a boundary: periods are never cut short.
                            phase   <= '0;
                            act_div <= sel_div;
                            trigger <= fire;
                            if (last) begin
                                state      <= ST_DRAIN;
                                drain_tmr  <= '0;
                                drain_seen <= 1'b0;
                            end
                        end else begin
                            phase   <= phase_inc;
                            trigger <= trigger && pulse_on;
                        end
                    end
                    ST_DRAIN: begin
                        phase   <= phase_inc;
                        trigger <= trigger && pulse_on;
                        if (adc_sampling) begin
                            drain_seen <= 1'b1;
                        end
                        if (drain_exit) begin
                            state      <= ST_IDLE;
                            running    <= 1'b0;
                            burst_done <= 1'b1;
                        end else if (!trigger && (drain_tmr != TMR_W'(TMO - 1))) begin
                            drain_tmr <= drain_tmr + TMR_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        trigger <= 1'b0;
                    end
                endcase
            end
        end
    end

    vuprs_sat_counter #(.WIDTH(BURST_WIDTH)) u_trig_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (fire),
        .count (trig_count)
    );

    vuprs_sat_counter #(.WIDTH(BURST_WIDTH)) u_ovr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (skip),
        .count (overrun_count)
    );

`ifdef SAMPLE_SCHED_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle count; ts_last holds the count of the cycle in which
    // the trigger first reads high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_cnt  <= '0;
            ts_last <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (fire) begin
                ts_last <= ts_cnt + 32'd1;
            end
        end
    end
`else
    assign ts_last = '0;
`endif

endmodule
